// File: rtl/sw_array_ctrl_pkg.sv
// Shared definitions for the Smith-Waterman PE-chain sequencer.
package sw_array_ctrl_pkg;

    // Sequencer states, one pass of CLR..CAPTURE per query chunk
    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StQload,
        StQlatch,
        StStream,
        StDrain,
        StCapture,
        StFin
    } state_e;

    // Cycles for a PE's max/x/y outputs to follow its last valid beat
    localparam int unsigned PeLatency     = 2;
    // Settle time after the final tail beat before max/x/y are captured
    localparam int unsigned DrainMargin   = PeLatency;
    // Extra DRAIN cycles beyond ref_len + NUM_PE before giving up on the tail
    localparam int unsigned WatchdogSlack = 8;

    // LSB position of PE k's base inside the packed s_par bus
    function automatic int unsigned spar_lsb(input int unsigned k, input int unsigned bp_width);
        return k * bp_width;
    endfunction

endpackage

// File: rtl/sw_best_tracker.sv
// Running maximum of chunk tail scores with their coordinates.
module sw_best_tracker
    import sw_array_ctrl_pkg::*;
#(
    parameter int unsigned CALC_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 10
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_update,
    input  logic [CALC_WIDTH-1:0]    i_score,
    input  logic [ADDRESS_WIDTH-1:0] i_x,
    input  logic [ADDRESS_WIDTH-1:0] i_y,
    output logic [CALC_WIDTH-1:0]    o_best_score,
    output logic [ADDRESS_WIDTH-1:0] o_best_x,
    output logic [ADDRESS_WIDTH-1:0] o_best_y
);

    logic [CALC_WIDTH-1:0]    r_best_score;
    logic [ADDRESS_WIDTH-1:0] r_best_x;
    logic [ADDRESS_WIDTH-1:0] r_best_y;
    logic                     w_better;

    // Strict signed compare: on a tie the earlier chunk keeps its coordinates
    assign w_better = $signed(i_score) > $signed(r_best_score);

    // Best registers start at 0, the local-alignment floor
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_best_score <= '0;
            r_best_x     <= '0;
            r_best_y     <= '0;
        end else if (i_update && w_better) begin
            r_best_score <= i_score;
            r_best_x     <= i_x;
            r_best_y     <= i_y;
        end
    end

    assign o_best_score = r_best_score;
    assign o_best_x     = r_best_x;
    assign o_best_y     = r_best_y;

endmodule

// File: rtl/sw_array_ctrl.sv
// Chunked sequencer for a linear systolic affine Smith-Waterman PE chain.
module sw_array_ctrl
    import sw_array_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PE        = 4,
    parameter int unsigned BP_WIDTH      = 2,
    parameter int unsigned CALC_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH-1:0]     query_len,
    input  logic [ADDRESS_WIDTH-1:0]     ref_len,
    output logic [ADDRESS_WIDTH-1:0]     q_addr,
    input  logic [BP_WIDTH-1:0]          q_data,
    output logic [ADDRESS_WIDTH-1:0]     r_addr,
    input  logic [BP_WIDTH-1:0]          r_data,
    output logic                         pe_rst_n,
    output logic [NUM_PE*BP_WIDTH-1:0]   s_par,
    output logic                         s_update,
    output logic [BP_WIDTH-1:0]          t_out,
    output logic                         valid_out,
    output logic [ADDRESS_WIDTH-1:0]     col_out,
    output logic                         bnd_sel,
    output logic [ADDRESS_WIDTH-1:0]     bnd_rd_addr,
    output logic                         bnd_we,
    output logic [ADDRESS_WIDTH-1:0]     bnd_wr_addr,
    input  logic                         tail_valid,
    input  logic [CALC_WIDTH-1:0]        tail_max,
    input  logic [ADDRESS_WIDTH-1:0]     tail_x,
    input  logic [ADDRESS_WIDTH-1:0]     tail_y,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [CALC_WIDTH-1:0]        best_score,
    output logic [ADDRESS_WIDTH-1:0]     best_x,
    output logic [ADDRESS_WIDTH-1:0]     best_y
);

    localparam int unsigned SparW = NUM_PE * BP_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] NumPeA     = ADDRESS_WIDTH'(NUM_PE);
    localparam logic [ADDRESS_WIDTH-1:0] OneA       = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0]   OneC       = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [ADDRESS_WIDTH:0]   WdExtra    = (ADDRESS_WIDTH + 1)'(NUM_PE + WatchdogSlack);
    localparam logic [ADDRESS_WIDTH-1:0] SettleLast = ADDRESS_WIDTH'(DrainMargin - 1);

    state_e                   r_state;
    state_e                   w_state_d;
    // One bit wider than addresses so the DRAIN watchdog cannot wrap
    logic [ADDRESS_WIDTH:0]   r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_settle;
    logic [ADDRESS_WIDTH-1:0] r_qlen;
    logic [ADDRESS_WIDTH-1:0] r_rlen;
    logic [ADDRESS_WIDTH-1:0] r_chunk_base;
    logic [ADDRESS_WIDTH-1:0] r_bnd_rd;
    logic [ADDRESS_WIDTH-1:0] r_bnd_wr;
    logic [ADDRESS_WIDTH-1:0] r_tcnt;
    logic [SparW-1:0]         r_spar;
    logic [SparW-1:0]         w_spar_shift;
    logic                     r_valid;
    logic                     r_bnd_sel;
    logic                     r_err;
    logic                     r_bad_done;

    logic                     w_bad_len;
    logic                     w_start_ok;
    logic                     w_start_bad;
    logic                     w_issue;
    logic                     w_last_issue;
    logic                     w_tail_done;
    logic                     w_settled;
    logic                     w_wd_expire;
    logic [ADDRESS_WIDTH:0]   w_wd_limit;
    logic [ADDRESS_WIDTH-1:0] w_next_base;

    assign w_bad_len    = (query_len == '0) || (ref_len == '0) || ((query_len % NumPeA) != '0);
    assign w_start_ok   = (r_state == StIdle) && start && !w_bad_len;
    assign w_start_bad  = (r_state == StIdle) && start && w_bad_len;
    assign w_issue      = (r_state == StStream);
    assign w_last_issue = (r_cnt == {1'b0, r_rlen - OneA});
    assign w_tail_done  = (r_tcnt == r_rlen);
    assign w_settled    = w_tail_done && (r_settle == SettleLast);
    assign w_wd_limit   = {1'b0, r_rlen} + WdExtra;
    assign w_wd_expire  = (r_state == StDrain) && !w_tail_done && (r_cnt == w_wd_limit - OneC);
    assign w_next_base  = r_chunk_base + NumPeA;

    // Next state plus the outputs decoded straight from the state
    always_comb begin
        w_state_d = r_state;
        pe_rst_n  = 1'b1;
        s_update  = 1'b0;
        q_addr    = '0;
        r_addr    = '0;
        busy      = (r_state != StIdle);
        done      = r_bad_done;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) w_state_d = StClr;
            end
            StClr: begin
                pe_rst_n  = 1'b0;
                w_state_d = StQload;
            end
            StQload: begin
                if (r_cnt < {1'b0, NumPeA}) q_addr = r_chunk_base + r_cnt[ADDRESS_WIDTH-1:0];
                // Extra cycle catches the last read returning from the sync RAM
                if (r_cnt == {1'b0, NumPeA}) w_state_d = StQlatch;
            end
            StQlatch: begin
                s_update  = 1'b1;
                w_state_d = StStream;
            end
            StStream: begin
                r_addr = r_cnt[ADDRESS_WIDTH-1:0];
                if (w_last_issue) w_state_d = StDrain;
            end
            StDrain: begin
                if (w_settled) begin
                    w_state_d = StCapture;
                end else if (w_wd_expire) begin
                    w_state_d = StFin;
                end
            end
            StCapture: begin
                w_state_d = (w_next_base < r_qlen) ? StClr : StFin;
            end
            StFin: begin
                done      = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Newest query base enters the top slice so base 0 ends in PE0's slice
    always_comb begin
        w_spar_shift = r_spar;
        for (int unsigned k = 0; k + 1 < NUM_PE; k++) begin
            w_spar_shift[spar_lsb(k, BP_WIDTH) +: BP_WIDTH] =
                r_spar[spar_lsb(k + 1, BP_WIDTH) +: BP_WIDTH];
        end
        w_spar_shift[spar_lsb(NUM_PE - 1, BP_WIDTH) +: BP_WIDTH] = q_data;
    end

    // State register and per-state cycle counters
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= (w_state_d != r_state) ? '0 : r_cnt + OneC;
            r_settle <= ((r_state == StDrain) && w_tail_done) ? r_settle + OneA : '0;
        end
    end

    // Run parameters, query chunk, stream/boundary registers and status pulses
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_qlen       <= '0;
            r_rlen       <= '0;
            r_chunk_base <= '0;
            r_spar       <= '0;
            r_valid      <= 1'b0;
            r_bnd_sel    <= 1'b0;
            r_bnd_rd     <= '0;
            r_bnd_wr     <= '0;
            r_tcnt       <= '0;
            r_err        <= 1'b0;
            r_bad_done   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_qlen       <= query_len;
                r_rlen       <= ref_len;
                r_chunk_base <= '0;
            end else if (r_state == StCapture) begin
                r_chunk_base <= w_next_base;
            end

            if ((r_state == StQload) && (r_cnt != '0)) r_spar <= w_spar_shift;

            // Stream sideband lines up with r_data arriving from the sync RAM
            r_valid   <= w_issue;
            r_bnd_sel <= w_issue && (r_chunk_base != '0);
            if (r_state == StClr) begin
                r_bnd_rd <= '0;
            end else if (w_issue) begin
                r_bnd_rd <= r_cnt[ADDRESS_WIDTH-1:0];
            end

            if (r_state == StClr) begin
                r_bnd_wr <= '0;
                r_tcnt   <= '0;
            end else if (tail_valid) begin
                r_bnd_wr <= r_bnd_wr + OneA;
                r_tcnt   <= r_tcnt + OneA;
            end

            r_err      <= w_start_bad || w_wd_expire;
            r_bad_done <= w_start_bad;
        end
    end

    sw_best_tracker #(
        .CALC_WIDTH    (CALC_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_best (
        .i_clk        (clk),
        .i_reset      (reset_i),
        .i_clear      (w_start_ok || w_start_bad),
        .i_update     (r_state == StCapture),
        .i_score      (tail_max),
        .i_x          (tail_x),
        .i_y          (tail_y),
        .o_best_score (best_score),
        .o_best_x     (best_x),
        .o_best_y     (best_y)
    );

    assign s_par       = r_spar;
    assign valid_out   = r_valid;
    assign t_out       = r_valid ? r_data : '0;
    assign col_out     = r_chunk_base;
    assign bnd_sel     = r_bnd_sel;
    assign bnd_rd_addr = r_bnd_rd;
    assign bnd_we      = tail_valid;
    assign bnd_wr_addr = r_bnd_wr;
    assign err         = r_err;

endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
- Sequencer for the linear systolic PE chain (two-piece affine Smith-Waterman).
- Splits the query into NUM_PE-base chunks. For each chunk it:
  - loads the chunk into the PEs,
  - streams the full reference through the chain,
  - routes last-PE boundary H/F/F_hat through an external boundary RAM into the next chunk's first PE,
  - drains the pipeline and captures the tail max/x/y.
- Reports the global best score and its coordinates to the host.

Parameters:
NUM_PE, 4, PEs in the chain (≥2)
BP_WIDTH, 2, base code width
CALC_WIDTH, 16, signed score width
ADDRESS_WIDTH, 10, sequence/RAM address width

Ports:
clk  in  1  clock
reset_i  in  1  synchronous active-high reset
start  in  1  one-cycle start pulse, honoured only in IDLE
query_len  in  ADDRESS_WIDTH  query bases, sampled on start
ref_len  in  ADDRESS_WIDTH  reference bases, sampled on start
q_addr  out  ADDRESS_WIDTH  query RAM address (sync read, 1-cycle latency)
q_data  in  BP_WIDTH  query RAM data
r_addr  out  ADDRESS_WIDTH  reference RAM address (sync read, 1-cycle latency)
r_data  in  BP_WIDTH  reference RAM data
pe_rst_n  out  1  to PE_rst of all PEs, active-low
s_par  out  NUM_PE*BP_WIDTH  chunk bases, PE k at slice k
s_update  out  1  one-cycle pulse: PEs latch s_par
t_out  out  BP_WIDTH  reference base into PE0
valid_out  out  1  PE0 valid_in
col_out  out  ADDRESS_WIDTH  PE0 col_in = chunk index * NUM_PE
bnd_sel  out  1  1: PE0 H/F/F_hat come from boundary RAM; 0: zero
bnd_rd_addr  out  ADDRESS_WIDTH  boundary RAM read address
bnd_we  out  1  boundary write enable (= tail valid)
bnd_wr_addr  out  ADDRESS_WIDTH  boundary write address
tail_valid  in  1  last PE valid_out
tail_max  in  CALC_WIDTH  last PE max_out (signed)
tail_x  in  ADDRESS_WIDTH  last PE x_out
tail_y  in  ADDRESS_WIDTH  last PE y_out
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse, illegal lengths
best_score  out  CALC_WIDTH  global max (signed), held until next start
best_x  out  ADDRESS_WIDTH  column of best_score
best_y  out  ADDRESS_WIDTH  row of best_score

Behaviour:
- Reset: state IDLE. All outputs 0 except pe_rst_n = 1. Counters and best registers cleared. Reset mid-operation aborts with no done pulse.
- start in IDLE with any of the following pulses err for one cycle and done in the same cycle, with best_* = 0:
  - query_len = 0,
  - ref_len = 0,
  - query_len not a multiple of NUM_PE.
- start while busy: ignored.
- FSM IDLE -> CLR -> QLOAD -> QLATCH -> STREAM -> DRAIN -> CAPTURE, then either CLR (more chunks) or FIN -> IDLE.
- CLR (1 cycle):
  - pe_rst_n = 0.
  - bnd_wr_addr and bnd_rd_addr cleared.
- QLOAD (NUM_PE+1 cycles):
  - q_addr = chunk_base + k for k = 0..NUM_PE-1.
  - Returning q_data is shifted into the s_par slices one cycle later.
- QLATCH (1 cycle): s_update = 1.
- STREAM:
  - r_addr runs 0..ref_len-1, one per cycle.
  - valid_out, t_out, bnd_sel and bnd_rd_addr are registered one cycle after each issue, so valid_out is high for exactly ref_len consecutive cycles.
  - bnd_sel = 0 in chunk 0, 1 otherwise.
  - bnd_rd_addr equals the row of the base on t_out.
  - col_out is constant within a chunk.
  - Exits one cycle after the last issue.
- Boundary write (all states): bnd_we = tail_valid. bnd_wr_addr increments after each write and wraps modulo 2^ADDRESS_WIDTH.
- DRAIN:
  - Waits until ref_len tail_valid pulses have been seen in this chunk, then a further 2 cycles for max/x/y to settle.
  - Watchdog of ref_len+NUM_PE+8 cycles; on expiry go to FIN with err pulsed.
- CAPTURE (1 cycle):
  - If tail_max > best_score (signed, strict), load best_score/x/y from tail. Ties keep the earlier chunk.
  - Then chunk_base += NUM_PE. If chunk_base < query_len go to CLR, else FIN.
- FIN: done = 1 for one cycle, busy drops the next cycle.
- Arithmetic:
  - chunk_base and counters are unsigned ADDRESS_WIDTH.
  - best_score compare is signed CALC_WIDTH.
  - best_score initialised to 0 (local alignment floor).

Decomposition:
- Shared package: state encoding, PE latency constant (2), drain margin, watchdog slack, bit-packing helper for s_par.
- One sub-module: sw_best_tracker (signed strict-greater compare plus registered best_score/x/y, clear-on-start).

Test Plan:
- Reset during STREAM (NUM_PE=4, ref_len=8, cycle 5) -> next cycle state IDLE, valid_out = 0, pe_rst_n = 1, no done.
- query_len=6 with NUM_PE=4 -> err and done pulse same cycle, busy stays 0, best_* = 0.
- query_len=4, ref_len=5, tail model with 4-cycle latency, tail_max=9, x=2, y=3 -> one pe_rst_n low cycle, one s_update, 5 valid cycles, col_out = 0, bnd_sel = 0, done with best = (9, 2, 3).
- query_len=8, chunk tail_max = 7 then 7 -> best keeps chunk-0 coordinates. Chunk 1 has col_out = 4, bnd_sel = 1, bnd_rd_addr 0..ref_len-1.
- Tail never asserts tail_valid -> watchdog err pulse after ref_len+NUM_PE+8 DRAIN cycles, then done.
- start asserted while busy -> ignored, and the current run's result is unchanged.
